// File: rtl/fft_mem_pkg.sv
// Shared definitions for the FFT ping-pong sample memory.
//   BIT_WIDTH / M : default component width and log2 FFT length
//   sample_t      : one complex word {Re, Im}
//   addr_t        : bank address
//   lanes_collide : both write lanes enabled on the same address
package fft_mem_pkg;
    localparam int BIT_WIDTH = 16;
    localparam int M         = 9;

    typedef logic [2*BIT_WIDTH-1:0] sample_t;
    typedef logic [M-1:0]           addr_t;

    // Addresses are zero-extended by the caller so one helper serves any M.
    function automatic logic lanes_collide(input logic        en_a,
                                           input logic        en_b,
                                           input logic [31:0] addr_a,
                                           input logic [31:0] addr_b);
        return en_a & en_b & (addr_a == addr_b);
    endfunction
endpackage

// File: rtl/fft_pingpong_ram_bank.sv
// ram_bank: one N x 2*BIT_WIDTH sample bank.
//   clk_i, reset_i             : clock, sync active-high reset (read regs only)
//   we_a_i/waddr_a_i/wdata_a_i : write port a
//   we_b_i/waddr_b_i/wdata_b_i : write port b (wins on equal address)
//   re_i, raddr_a_i, raddr_b_i : shared read enable, two read addresses
//   rdata_a_o, rdata_b_o       : registered read data, held while re_i=0
module ram_bank #(
    parameter int BIT_WIDTH = 16,
    parameter int M         = 9
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   we_a_i,
    input  logic [M-1:0]           waddr_a_i,
    input  logic [2*BIT_WIDTH-1:0] wdata_a_i,
    input  logic                   we_b_i,
    input  logic [M-1:0]           waddr_b_i,
    input  logic [2*BIT_WIDTH-1:0] wdata_b_i,
    input  logic                   re_i,
    input  logic [M-1:0]           raddr_a_i,
    input  logic [M-1:0]           raddr_b_i,
    output logic [2*BIT_WIDTH-1:0] rdata_a_o,
    output logic [2*BIT_WIDTH-1:0] rdata_b_o
);
    localparam int N = 1 << M;

    logic [2*BIT_WIDTH-1:0] mem_q [N];
    logic [2*BIT_WIDTH-1:0] rdata_a_q, rdata_b_q;

    // Port b is written last, so its value survives an equal-address write.
    always_ff @(posedge clk_i) begin
        if (we_a_i) mem_q[waddr_a_i] <= wdata_a_i;
        if (we_b_i) mem_q[waddr_b_i] <= wdata_b_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else if (re_i) begin
            rdata_a_q <= mem_q[raddr_a_i];
            rdata_b_q <= mem_q[raddr_b_i];
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;
endmodule

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two-bank ping-pong sample memory for the radix-2 FFT.
//   clk_i, reset_i           : clock, sync active-high reset
//   swap_i                   : end-of-stage pulse, exchanges bank roles
//   rd_en_i, rd_addr_a/b_i   : dual-lane read from bank[bank_sel]
//   rd_data_a/b_o, rd_valid_o: 1-cycle-latency registered read result
//   wr_en_a/b_i, wr_addr_a/b_i, wr_data_a/b_i : dual-lane write to bank[!bank_sel]
//   bank_sel_o               : current read bank
//   stage_o                  : completed stages, 0..M-1
//   fft_done_o               : pulse when the stage count wraps at M
//   wr_collision_o           : pulse when both lanes wrote the same address
module fft_pingpong_ram #(
    parameter int BIT_WIDTH = fft_mem_pkg::BIT_WIDTH,
    parameter int M         = fft_mem_pkg::M,
    localparam int DW       = 2*BIT_WIDTH,
    localparam int SW       = $clog2(M+1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          swap_i,
    input  logic          rd_en_i,
    input  logic [M-1:0]  rd_addr_a_i,
    input  logic [M-1:0]  rd_addr_b_i,
    output logic [DW-1:0] rd_data_a_o,
    output logic [DW-1:0] rd_data_b_o,
    output logic          rd_valid_o,
    input  logic          wr_en_a_i,
    input  logic          wr_en_b_i,
    input  logic [M-1:0]  wr_addr_a_i,
    input  logic [M-1:0]  wr_addr_b_i,
    input  logic [DW-1:0] wr_data_a_i,
    input  logic [DW-1:0] wr_data_b_i,
    output logic          bank_sel_o,
    output logic [SW-1:0] stage_o,
    output logic          fft_done_o,
    output logic          wr_collision_o
);
    import fft_mem_pkg::*;

    logic          bank_sel_q, bank_sel_d;
    logic [SW-1:0] stage_q, stage_d;
    logic          done_q, done_d;
    logic          coll_q, coll_d;
    logic          rvalid_q, rvalid_d;
    logic          rsel_q, rsel_d;     // bank that served the outstanding read

    // Reset suppresses every memory access issued in that cycle.
    logic live;
    logic re0, re1, we0_a, we0_b, we1_a, we1_b;
    logic [DW-1:0] r0_a, r0_b, r1_a, r1_b;

    assign live  = ~reset_i;
    assign re0   = live & rd_en_i & ~bank_sel_q;
    assign re1   = live & rd_en_i &  bank_sel_q;
    assign we0_a = live & wr_en_a_i &  bank_sel_q;
    assign we0_b = live & wr_en_b_i &  bank_sel_q;
    assign we1_a = live & wr_en_a_i & ~bank_sel_q;
    assign we1_b = live & wr_en_b_i & ~bank_sel_q;

    ram_bank #(.BIT_WIDTH(BIT_WIDTH), .M(M)) u_bank0 (
        .clk_i(clk_i), .reset_i(reset_i),
        .we_a_i(we0_a), .waddr_a_i(wr_addr_a_i), .wdata_a_i(wr_data_a_i),
        .we_b_i(we0_b), .waddr_b_i(wr_addr_b_i), .wdata_b_i(wr_data_b_i),
        .re_i(re0), .raddr_a_i(rd_addr_a_i), .raddr_b_i(rd_addr_b_i),
        .rdata_a_o(r0_a), .rdata_b_o(r0_b)
    );

    ram_bank #(.BIT_WIDTH(BIT_WIDTH), .M(M)) u_bank1 (
        .clk_i(clk_i), .reset_i(reset_i),
        .we_a_i(we1_a), .waddr_a_i(wr_addr_a_i), .wdata_a_i(wr_data_a_i),
        .we_b_i(we1_b), .waddr_b_i(wr_addr_b_i), .wdata_b_i(wr_data_b_i),
        .re_i(re1), .raddr_a_i(rd_addr_a_i), .raddr_b_i(rd_addr_b_i),
        .rdata_a_o(r1_a), .rdata_b_o(r1_b)
    );

    always_comb begin
        bank_sel_d = bank_sel_q;
        stage_d    = stage_q;
        done_d     = 1'b0;
        rvalid_d   = rd_en_i;
        // The output mux follows the bank read at issue time, so a swap in
        // the issue cycle does not redirect the returning data.
        rsel_d     = rd_en_i ? bank_sel_q : rsel_q;
        coll_d     = lanes_collide(wr_en_a_i, wr_en_b_i,
                                   32'(wr_addr_a_i), 32'(wr_addr_b_i));
        if (swap_i) begin
            bank_sel_d = ~bank_sel_q;
            // Stage M is never held: it wraps straight to 0 and flags done.
            if (stage_q == SW'(M-1)) begin
                stage_d = '0;
                done_d  = 1'b1;
            end else begin
                stage_d = stage_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bank_sel_q <= 1'b0;
            stage_q    <= '0;
            done_q     <= 1'b0;
            coll_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            rsel_q     <= 1'b0;
        end else begin
            bank_sel_q <= bank_sel_d;
            stage_q    <= stage_d;
            done_q     <= done_d;
            coll_q     <= coll_d;
            rvalid_q   <= rvalid_d;
            rsel_q     <= rsel_d;
        end
    end

    assign rd_data_a_o    = rsel_q ? r1_a : r0_a;
    assign rd_data_b_o    = rsel_q ? r1_b : r0_b;
    assign rd_valid_o     = rvalid_q;
    assign bank_sel_o     = bank_sel_q;
    assign stage_o        = stage_q;
    assign fft_done_o     = done_q;
    assign wr_collision_o = coll_q;
endmodule

// File: doc/fft_pingpong_ram.md
# fft_pingpong_ram

Parametrised ping-pong sample memory for the radix-2 FFT datapath. It holds two banks of 2^M complex words, each word {Re, Im}. In every cycle the butterfly reads two words from the current read bank and writes two results into the other bank. A swap pulse at the end of each stage exchanges the bank roles and advances a stage counter, which flags completion after M stages. It sits between the input capture/AGU and the butterfly core, beside the twiddle ROM.

## Interface
- BIT_WIDTH, 16, width of each Re/Im component; a word is 2*BIT_WIDTH bits, {Re, Im}.
- M, 9, log2 of FFT length; each bank holds N = 2^M words.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- swap  in  1  end-of-stage pulse; exchanges read/write banks.
- rd_en  in  1  read request for both lanes.
- rd_addr_a, rd_addr_b  in  M  read addresses in the read bank.
- rd_data_a, rd_data_b  out  2*BIT_WIDTH  registered read data.
- rd_valid  out  1  rd_data is valid this cycle.
- wr_en_a, wr_en_b  in  1 each  per-lane write enables to the write bank.
- wr_addr_a, wr_addr_b  in  M  write addresses.
- wr_data_a, wr_data_b  in  2*BIT_WIDTH  write data.
- bank_sel  out  1  current read bank; the write bank is !bank_sel.
- stage  out  $clog2(M+1)  number of completed stages.
- fft_done  out  1  one-cycle pulse when the stage count reaches M.
- wr_collision  out  1  one-cycle pulse when both lanes write the same address.

## Operation
- Bank roles:
  - Reads always target bank[bank_sel].
  - Writes always target bank[!bank_sel].
  - Reads and writes therefore never touch the same bank in a cycle, so no read-during-write hazard exists.
- Swap: on a cycle with swap=1, bank_sel toggles on that edge.
  - Reads and writes sampled in the same cycle use the pre-swap selection.
- Stage counter:
  - Each swap increments stage.
  - The swap that takes stage from M-1 to M asserts fft_done on the next cycle and loads stage to 0 instead of M. stage therefore ranges 0..M-1 at rest, and M is never visible.
- Load phase: an upstream block writes N samples through lane a only (wr_en_b=0), then pulses swap. The loaded data becomes the stage-0 read bank. This swap also counts toward stage. The controller issues M+1 swaps per FFT, and the fft_done pulse aligns with the final butterfly stage.
  - Correction, decided: the load-phase swap is counted, so fft_done fires after the load swap plus M-1 butterfly swaps. The controller must account for this offset.
- Write collision: when wr_en_a and wr_en_b are both high with wr_addr_a==wr_addr_b:
  - lane b's data is stored;
  - wr_collision pulses next cycle.
- Reset:
  - bank_sel=0, stage=0, rd_valid=0, rd_data_a/b=0, fft_done=0, wr_collision=0.
  - Memory contents are not cleared.
  - Reset mid-stage discards the in-flight read (rd_valid=0 the next cycle).
  - Reset has priority over swap, rd_en and wr_en in the same cycle; writes in a reset cycle are suppressed.
- Address width is exactly M bits; there are no out-of-range addresses.

## Timing
- Read latency is 1 cycle: rd_en at edge k gives rd_data and rd_valid=1 after edge k+1.
- Read data comes from the bank selected at issue time, even if swap occurs in the same cycle.
- rd_data holds its last value when rd_en=0; rd_valid=0 in that case.
- A write at edge k is readable after a swap, by a read issued at edge k+1 or later.
- Back-to-back reads and writes every cycle are supported, giving a throughput of 2 reads and 2 writes per clock.
- fft_done and wr_collision are registered and exactly one cycle wide.
- Consecutive swap cycles are each counted.

## Structure
- Package fft_mem_pkg contains:
  - localparams BIT_WIDTH and M defaults;
  - typedef sample_t (logic [2*BIT_WIDTH-1:0]);
  - typedef addr_t (logic [M-1:0]).
- Sub-module ram_bank: one N×2*BIT_WIDTH array with two write ports (b wins on equal address) and two registered read ports. It is instantiated twice.
- The top level holds bank_sel, stage/fft_done logic, enable steering, the output mux and collision detection.

## Test plan
- Reset then idle: all outputs 0, bank_sel=0, stage=0. After 5 idle cycles, still rd_valid=0.
- Load and swap: write 0x0001_0000+i to addr i on lane a for i=0..511, swap, then read addr 5/300. Expect 0x0001_0005/0x0001_012C one cycle later with rd_valid=1 and bank_sel=1.
- Ping-pong integrity: read addr 3/4 while writing 0xAAAA_5555 to addr 3 in the write bank, same cycle. Expect the read to return the old data; after a swap, addr 3 reads 0xAAAA_5555.
- Swap same cycle as read: rd_en with swap=1. Expect the data to come from the old bank and bank_sel to toggle.
- Collision: wr_addr_a=wr_addr_b=7 with data 0x1111_1111/0x2222_2222. Expect wr_collision pulse; after a swap, addr 7 reads 0x2222_2222.
- Stage count with M=3: issue 3 swaps. Expect stage 1,2,0 and fft_done high one cycle after the 3rd swap. A reset asserted between the 1st and 2nd swaps returns stage to 0 and bank_sel to 0.
